// File: rtl/wb_init_pkg.sv
// Shared types and constants for the Wishbone classic-cycle initiator.
// Holds the FSM state encoding, the per-beat address step and the timeout counter sizing.
package wb_init_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    localparam int unsigned ADDR_STEP = 4;

    // Width of a counter that must hold the value TIMEOUT; at least one bit even when disabled.
    function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_initiator.sv
// Wishbone classic-cycle initiator: turns a valid/ready request into single or incrementing
// bursts, returns one response per beat and aborts a beat whose ack never arrives.
module wb_initiator
    import wb_init_pkg::*;
#(
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    input  logic [3:0]        req_sel,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              wdata_next,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_last,

    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i
);

    localparam int unsigned TMO_W = tmo_cnt_w(TIMEOUT);

    state_e           state;
    logic [3:0]       beats_left;
    logic [TMO_W-1:0] tmo_cnt;

    logic last_beat;
    logic ack_edge;
    logic tmo_hit;

    assign req_ready = (state == IDLE);
    assign last_beat = (beats_left == 4'd0);
    assign ack_edge  = wbm_stb_o && wbm_ack_i;

    // Fires on the edge that would bring the counter up to TIMEOUT; an ack on that edge wins.
    assign tmo_hit = (TIMEOUT != 0) && ((32'(tmo_cnt) + 32'd1) == TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beats_left <= 4'd0;
            tmo_cnt    <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= 4'd0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            rsp_last   <= 1'b0;
            wdata_next <= 1'b0;
        end else begin
            wdata_next <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        wbm_we_o   <= req_we;
                        wbm_sel_o  <= req_sel;
                        wbm_adr_o  <= req_addr;
                        wbm_dat_o  <= req_we ? req_wdata : '0;
                        beats_left <= req_len;
                        tmo_cnt    <= '0;
                        wbm_cyc_o  <= 1'b1;
                        wbm_stb_o  <= 1'b1;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (ack_edge) begin
                        wbm_stb_o  <= 1'b0;
                        wbm_cyc_o  <= !last_beat;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err    <= 1'b0;
                        rsp_last   <= last_beat;
                        wdata_next <= wbm_we_o;
                        state      <= RESP;
                    end else if (tmo_hit) begin
                        wbm_stb_o  <= 1'b0;
                        wbm_cyc_o  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= '0;
                        rsp_err    <= 1'b1;
                        rsp_last   <= 1'b1;
                        beats_left <= 4'd0;
                        state      <= RESP;
                    end else if (tmo_cnt != {TMO_W{1'b1}}) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            state <= IDLE;
                        end else begin
                            // cyc is still high here; only stb needs to come back.
                            beats_left <= beats_left - 4'd1;
                            wbm_adr_o  <= wbm_adr_o + ADDR_W'(ADDR_STEP);
                            wbm_dat_o  <= wbm_we_o ? req_wdata : '0;
                            tmo_cnt    <= '0;
                            wbm_stb_o  <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: a bus responder model and a response monitor pop
// expected beats/responses from queues that the directed stimulus fills.
module tb_wb_initiator;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        last;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [27:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [27:0] req_addr;
    logic [3:0]  req_len;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic        wdata_next;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_last;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [27:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    wb_initiator #(
        .ADDR_W (28),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_sel   (req_sel),
        .req_wdata (req_wdata),
        .wdata_next(wdata_next),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_last  (rsp_last),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    rsp_t  exp_rsp[$];
    beat_t exp_beat[$];

    int ack_wait = 0;
    int wait_cnt = 0;
    int wn_total = 0;
    int wd_base  = 0;
    int cyc_cycles = 0;
    int stb_cycles = 0;
    int cyc_drops  = 0;
    logic cyc_prev = 1'b0;
    logic [31:0] wd_tbl [16];
    rsp_t  got_rsp;
    beat_t got_beat;

    assign req_wdata = wd_tbl[4'(wn_total - wd_base)];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] rd_model(input logic [27:0] a);
        return (a == 28'h10) ? 32'hDEADBEEF : {4'h5, a};
    endfunction

    // Responder: ack after ack_wait stall cycles, check each beat against the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            wbm_ack_i = 1'b0;
            wait_cnt  = 0;
        end else if (wbm_ack_i) begin
            wbm_ack_i = 1'b0;
            wait_cnt  = 0;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            if (wait_cnt == ack_wait) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = wbm_we_o ? 32'h0 : rd_model(wbm_adr_o);
                if (exp_beat.size() == 0) begin
                    check("bus_unexpected_beat", 64'(wbm_adr_o), 64'hFFFF_FFFF);
                end else begin
                    got_beat = exp_beat.pop_front();
                    check("bus_we", 64'(wbm_we_o), 64'(got_beat.we));
                    check("bus_adr", 64'(wbm_adr_o), 64'(got_beat.adr));
                    check("bus_sel", 64'(wbm_sel_o), 64'(got_beat.sel));
                    if (got_beat.we) check("bus_dat", 64'(wbm_dat_o), 64'(got_beat.dat));
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", {rsp_rdata, 30'd0, rsp_err, rsp_last}, 64'hFFFF_FFFF);
            end else begin
                got_rsp = exp_rsp.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(got_rsp.rdata));
                check("rsp_err", 64'(rsp_err), 64'(got_rsp.err));
                check("rsp_last", 64'(rsp_last), 64'(got_rsp.last));
            end
        end
    end

    // Write-data source plus bus activity counters.
    always @(negedge clk) begin
        if (wdata_next) wn_total++;
        if (wbm_cyc_o) cyc_cycles++;
        if (wbm_stb_o) stb_cycles++;
        if (cyc_prev && !wbm_cyc_o) cyc_drops++;
        cyc_prev = wbm_cyc_o;
    end

    task automatic push_beat(input logic we, input logic [27:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat);
        exp_beat.push_back('{we: we, adr: adr, sel: sel, dat: dat});
    endtask

    task automatic push_rsp(input logic [31:0] rdata, input logic err, input logic last);
        exp_rsp.push_back('{rdata: rdata, err: err, last: last});
    endtask

    task automatic send(input logic we, input logic [27:0] addr, input logic [3:0] len,
                        input logic [3:0] sel);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL req_accept_timeout: req_ready=%0b required 1", req_ready);
        end
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        req_sel   = sel;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_rsp.size() != 0 || exp_beat.size() != 0 || !req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s_done: %0d rsp and %0d beats outstanding, required 0", name,
                     exp_rsp.size(), exp_beat.size());
            exp_rsp.delete();
            exp_beat.delete();
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int s0;
        int d0;
        int n;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        for (int i = 0; i < 16; i++) wd_tbl[i] = 32'h0;

        #3;
        check("reset_outputs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, rsp_valid, rsp_err,
                                rsp_last, wdata_next}, 64'h0);
        check("reset_adr_dat", {wbm_adr_o, wbm_dat_o}, 64'h0);
        check("reset_rdata", 64'(rsp_rdata), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'h1);

        // Single read with 2 wait states.
        ack_wait = 2;
        push_beat(1'b0, 28'h0000010, 4'hF, 32'h0);
        push_rsp(32'hDEADBEEF, 1'b0, 1'b1);
        c0 = cyc_cycles;
        send(1'b0, 28'h0000010, 4'd0, 4'hF);
        wait_done("single_read");
        check("single_read_cyc_cycles", 64'(cyc_cycles - c0), 64'd3);

        // Four-beat write burst, zero wait.
        ack_wait = 0;
        wd_tbl[0] = 32'h11;
        wd_tbl[1] = 32'h22;
        wd_tbl[2] = 32'h33;
        wd_tbl[3] = 32'h44;
        wd_base = wn_total;
        push_beat(1'b1, 28'h100, 4'hF, 32'h11);
        push_beat(1'b1, 28'h104, 4'hF, 32'h22);
        push_beat(1'b1, 28'h108, 4'hF, 32'h33);
        push_beat(1'b1, 28'h10C, 4'hF, 32'h44);
        push_rsp(32'h0, 1'b0, 1'b0);
        push_rsp(32'h0, 1'b0, 1'b0);
        push_rsp(32'h0, 1'b0, 1'b0);
        push_rsp(32'h0, 1'b0, 1'b1);
        c0 = cyc_cycles;
        d0 = cyc_drops;
        send(1'b1, 28'h100, 4'd3, 4'hF);
        wait_done("write_burst");
        check("write_burst_cyc_drops", 64'(cyc_drops - d0), 64'd1);
        check("write_burst_cyc_cycles", 64'(cyc_cycles - c0), 64'd7);
        check("write_burst_wdata_next", 64'(wn_total - wd_base), 64'd4);

        // Two-beat read with response backpressure.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        push_beat(1'b0, 28'h200, 4'h3, 32'h0);
        push_beat(1'b0, 28'h204, 4'h3, 32'h0);
        push_rsp(32'h50000200, 1'b0, 1'b0);
        push_rsp(32'h50000204, 1'b0, 1'b1);
        send(1'b0, 28'h200, 4'd1, 4'h3);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_first_rsp_seen", 64'(rsp_valid), 64'h1);
        for (int i = 0; i < 5; i++) begin
            check("bp_stall_stb_cyc", {62'd0, wbm_stb_o, wbm_cyc_o}, 64'h1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_stb_before_handshake", 64'(wbm_stb_o), 64'h0);
        @(posedge clk);
        #1 check("bp_stb_after_handshake", 64'(wbm_stb_o), 64'h1);
        wait_done("backpressure");

        // No ack: timeout after 8 stb-high cycles cancels the burst.
        ack_wait = 1000;
        push_rsp(32'h0, 1'b1, 1'b1);
        c0 = cyc_cycles;
        s0 = stb_cycles;
        send(1'b0, 28'h300, 4'd2, 4'hF);
        wait_done("timeout");
        check("timeout_stb_cycles", 64'(stb_cycles - s0), 64'd8);
        check("timeout_cyc_cycles", 64'(cyc_cycles - c0), 64'd8);
        check("timeout_req_ready", 64'(req_ready), 64'h1);

        // Ack on the 8th stb cycle beats the timeout.
        ack_wait = 7;
        push_beat(1'b0, 28'h40, 4'hF, 32'h0);
        push_rsp(32'h50000040, 1'b0, 1'b1);
        s0 = stb_cycles;
        send(1'b0, 28'h40, 4'd0, 4'hF);
        wait_done("ack_tmo_tie");
        check("ack_tmo_tie_stb_cycles", 64'(stb_cycles - s0), 64'd8);

        // Reset during beat 2 of 4.
        ack_wait = 3;
        push_beat(1'b0, 28'h500, 4'hF, 32'h0);
        push_rsp(32'h50000500, 1'b0, 1'b0);
        send(1'b0, 28'h500, 4'd3, 4'hF);
        n = 0;
        @(negedge clk);
        while ((exp_rsp.size() != 0 || !wbm_stb_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_reset_beat2_issued", 64'(wbm_stb_o), 64'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o}, 64'h0);
        check("mid_reset_dat", 64'(wbm_dat_o), 64'h0);
        check("mid_reset_rsp", {rsp_rdata, 29'd0, rsp_valid, rsp_err, rsp_last}, 64'h0);
        check("mid_reset_wdata_next", 64'(wdata_next), 64'h0);
        exp_beat.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_idle", {61'd0, rsp_valid, wbm_cyc_o, req_ready}, 64'h1);

        ack_wait = 0;
        wd_tbl[0] = 32'h66;
        wd_base = wn_total;
        push_beat(1'b1, 28'h600, 4'h1, 32'h66);
        push_rsp(32'h0, 1'b0, 1'b1);
        send(1'b1, 28'h600, 4'd0, 4'h1);
        wait_done("post_reset_write");

        // Address wraps to zero.
        push_beat(1'b0, 28'hFFFFFFC, 4'hF, 32'h0);
        push_beat(1'b0, 28'h0000000, 4'hF, 32'h0);
        push_rsp(32'h5FFFFFFC, 1'b0, 1'b0);
        push_rsp(32'h50000000, 1'b0, 1'b1);
        send(1'b0, 28'hFFFFFFC, 4'd1, 4'hF);
        wait_done("addr_wrap");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
